// File: rtl/bridge_pkg.sv
// Shared constants, FSM state type and nibble-to-ASCII helper for the bus-to-UART response bridge.
package bridge_pkg;

    localparam logic [7:0] PREAMBLE = 8'h44;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F'
    function automatic logic [7:0] to_ascii_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Synchronous FIFO, head visible combinationally on pop_dat_o; push into a full FIFO
// succeeds only when a pop happens on the same edge, otherwise the push is discarded.
module bridge_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty when the index bits match
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/bridge_tx_buffered.sv
// Queues bus read responses and streams each as "D" + hex digits + CR[LF] to a byte transmitter.
// start_o holds until done_i accepts the byte; back-to-back messages keep start_o high throughout.
module bridge_tx_buffered
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int APPEND_LF  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            rw_i,
    input  logic                            valid_i,
    output logic [7:0]                      data_o,
    output logic                            start_o,
    input  logic                            done_i,
    output logic                            overflow_o,
    input  logic                            clr_ovf_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o
);

    localparam int N       = DATA_WIDTH / 4;
    localparam int MSG_LEN = 1 + N + ((APPEND_LF != 0) ? 2 : 1);
    localparam int IDX_W   = $clog2(MSG_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    start_q, start_d;
    logic                    ovf_q, ovf_d;

    logic                    push_req;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_dat;
    logic                    xfer;
    logic [3:0]              nib;

    assign push_req   = valid_i && !rw_i;
    assign xfer       = start_q && done_i;
    assign start_o    = start_q;
    assign overflow_o = ovf_q;

    bridge_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_req),
        .push_dat_i (data_i),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level_o)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        start_d  = start_q;
        fifo_pop = 1'b0;
        if (state_q == IDLE) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                hold_d   = fifo_dat;
                idx_d    = '0;
                state_d  = SEND;
                start_d  = 1'b1;
            end
        end else if (xfer) begin
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                // Chain straight into the next message so start_o never dips
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_dat;
                end else begin
                    state_d = IDLE;
                    start_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // A new drop wins over a same-edge clear
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (push_req && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i + 1)) begin
                nib = hold_q[DATA_WIDTH-4*(i+1) +: 4];
            end
        end
        if (idx_q == '0) begin
            data_o = PREAMBLE;
        end else if (idx_q <= IDX_W'(N)) begin
            data_o = to_ascii_hex(nib);
        end else if (idx_q == IDX_W'(N + 1)) begin
            data_o = CR;
        end else begin
            data_o = LF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bridge_tx_buffered.sv
// Scoreboarded bench: stimulus queues expected bytes, transmitter models pop and compare on each byte.
module tb_bridge_tx_buffered;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_i;
    logic        rw_i, valid_i, done_i, clr_ovf_i;
    logic [7:0]  data_o;
    logic        start_o, overflow_o;
    logic [2:0]  level_o;

    logic [7:0]  d2_data_i;
    logic        d2_rw_i, d2_valid_i, d2_done_i, d2_clr_ovf_i;
    logic [7:0]  d2_data_o;
    logic        d2_start_o, d2_overflow_o;
    logic [2:0]  d2_level_o;

    int          checks = 0;
    int          errors = 0;
    int          xfer_cnt = 0;
    int          d2_xfer_cnt = 0;
    logic        tx_en = 1'b1;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp2_q[$];

    always #5 clk = ~clk;

    bridge_tx_buffered #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .APPEND_LF(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
        .data_o(data_o), .start_o(start_o), .done_i(done_i), .overflow_o(overflow_o),
        .clr_ovf_i(clr_ovf_i), .level_o(level_o)
    );

    bridge_tx_buffered #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .APPEND_LF(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .data_i(d2_data_i), .rw_i(d2_rw_i), .valid_i(d2_valid_i),
        .data_o(d2_data_o), .start_o(d2_start_o), .done_i(d2_done_i), .overflow_o(d2_overflow_o),
        .clr_ovf_i(d2_clr_ovf_i), .level_o(d2_level_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_msg(input logic [63:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bytes[8*i +: 8]);
    endtask

    task automatic read16(input logic [15:0] v);
        valid_i = 1'b1; rw_i = 1'b0; data_i = v;
        @(negedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (xfer_cnt < target) chk("timeout_xfers", xfer_cnt, target);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || start_o || done_i) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_start_low"}, start_o, 0);
    endtask

    // Transmitter model for the 16-bit instance: one-cycle done_i pulse per byte, 10 cycles apart
    initial begin
        int gap = 0;
        done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (done_i) begin
                done_i = 1'b0;
                gap = 0;
            end else if (tx_en && rst_n && start_o && gap >= 10) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", data_o, 8'hxx);
                end else begin
                    chk("byte", data_o, exp_q.pop_front());
                end
                done_i = 1'b1;
                xfer_cnt++;
            end else if (gap < 100) begin
                gap++;
            end
        end
    end

    initial begin
        int gap = 0;
        d2_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (d2_done_i) begin
                d2_done_i = 1'b0;
                gap = 0;
            end else if (rst_n && d2_start_o && gap >= 10) begin
                if (exp2_q.size() == 0) begin
                    chk("unexpected_byte8", d2_data_o, 8'hxx);
                end else begin
                    chk("byte8", d2_data_o, exp2_q.pop_front());
                end
                d2_done_i = 1'b1;
                d2_xfer_cnt++;
            end else if (gap < 100) begin
                gap++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int lows;
        int n;
        rst_n = 1'b0; data_i = '0; rw_i = 1'b0; valid_i = 1'b0; clr_ovf_i = 1'b0;
        d2_data_i = '0; d2_rw_i = 1'b0; d2_valid_i = 1'b0; d2_clr_ovf_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_start", start_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_data", data_o, 8'h44);
        chk("rst_start8", d2_start_o, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // 1: single read
        expect_msg(64'h44_31_32_33_34_0D_0A, 7);
        read16(16'h1234);
        chk("t1_level_after_push", level_o, 1);
        chk("t1_start_after_push", start_o, 0);
        @(negedge clk); #1;
        chk("t1_start_after_pop", start_o, 1);
        chk("t1_level_after_pop", level_o, 0);
        wait_idle("t1", 300);

        // 2: write is ignored
        valid_i = 1'b1; rw_i = 1'b1; data_i = 16'hBEEF;
        @(negedge clk); #1;
        valid_i = 1'b0; rw_i = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t2_start", start_o, 0);
        chk("t2_level", level_o, 0);

        // 3: overflow with transmitter stalled
        tx_en = 1'b0;
        for (int k = 1; k <= 5; k++) expect_msg({40'h44_30_30_30, 8'h30 + 8'(k), 16'h0D_0A}, 7);
        for (int k = 1; k <= 6; k++) begin
            valid_i = 1'b1; rw_i = 1'b0; data_i = 16'(k);
            @(negedge clk); #1;
        end
        valid_i = 1'b0;
        chk("t3_level_full", level_o, 4);
        chk("t3_ovf_set", overflow_o, 1);
        valid_i = 1'b1; data_i = 16'h0007; clr_ovf_i = 1'b1;
        @(negedge clk); #1;
        valid_i = 1'b0;
        chk("t3_ovf_clr_vs_drop", overflow_o, 1);
        @(negedge clk); #1;
        clr_ovf_i = 1'b0;
        chk("t3_ovf_cleared", overflow_o, 0);
        chk("t3_level_still_full", level_o, 4);
        tx_en = 1'b1;
        wait_idle("t3", 1500);

        // 4: back-to-back messages keep start_o high
        base = xfer_cnt;
        expect_msg(64'h44_41_35_41_35_0D_0A, 7);
        expect_msg(64'h44_30_46_30_46_0D_0A, 7);
        read16(16'hA5A5);
        read16(16'h0F0F);
        wait_xfers(base + 1, 100);
        lows = 0;
        n = 0;
        while (xfer_cnt < base + 14 && n < 600) begin
            if (!start_o) lows++;
            @(negedge clk); #1; n++;
        end
        chk("t4_xfers", xfer_cnt - base, 14);
        chk("t4_start_gaps", lows, 0);
        wait_idle("t4", 100);

        // 5: 8-bit, CR-only instance
        exp2_q.push_back(8'h44); exp2_q.push_back(8'h41);
        exp2_q.push_back(8'h42); exp2_q.push_back(8'h0D);
        d2_valid_i = 1'b1; d2_data_i = 8'hAB;
        @(negedge clk); #1;
        d2_valid_i = 1'b0;
        n = 0;
        while ((exp2_q.size() != 0 || d2_start_o || d2_done_i) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("t5_xfers", d2_xfer_cnt, 4);
        chk("t5_start_low", d2_start_o, 0);

        // 6: reset in the middle of a message
        base = xfer_cnt;
        expect_msg(64'h44_31_31, 3);
        read16(16'h1111);
        read16(16'h2222);
        wait_xfers(base + 3, 200);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_start", start_o, 0);
        chk("t6_rst_level", level_o, 0);
        chk("t6_rst_data", data_o, 8'h44);
        chk("t6_rst_queue", exp_q.size(), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        expect_msg(64'h44_30_30_46_46_0D_0A, 7);
        read16(16'h00FF);
        wait_idle("t6", 300);
        chk("t6_total_xfers", xfer_cnt - base, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
